data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder that serves load/store requests from the pipeline's MEM stage (mem_read, mem_write, ALU address, rt write data).
- Sits behind the EX/MEM register.
- Drives mem_stall into the hazard unit so that PC, IF/ID, ID/EX, EX/MEM and MEM/WB hold while an access is in flight.
- Returns load data to the MEM/WB data register.

---
 rtl/dmem_pkg.sv | 63 ++++++
 rtl/dmem_array.sv | 39 +++
 rtl/data_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// FSM encoding, default latency, word-index width and address checking.
// Optional byte-lane stores are selected with the DMEM_BYTE_EN macro.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_DEF_LATENCY = 2;
    // The wait counter must hold LATENCY-1 for LATENCY up to 15.
    localparam int DMEM_CNT_W = 4;

    // Ceiling log2. Sizes the word index for a power-of-2 DEPTH_WORDS.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Legal byte-lane patterns are contiguous and naturally aligned:
    // single bytes, aligned halfwords, or the full word.
    function automatic logic dmem_lanes_ok(input logic [3:0] be);
        logic ok;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Returns 1 when the captured request must be rejected.
    // Out-of-range addresses are always rejected. With byte lanes enabled,
    // a store is judged by its lane pattern instead of addr[1:0]; loads
    // always read a full word and therefore keep the strict alignment rule.
    function automatic logic dmem_addr_err(
        input logic [63:0] addr,
        input int          depth_words,
        input logic        is_store,
        input logic [3:0]  be,
        input logic        use_be
    );
        logic [63:0] limit;
        logic        err;
        limit = 64'(depth_words) << 2;
        err   = (addr >= limit);
        if (use_be && is_store) begin
            err = err | ~dmem_lanes_ok(be);
        end else begin
            err = err | (addr[1:0] != 2'b00);
        end
        return err;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: single port, synchronous lane-masked write, registered read.
// Latency: read data valid the cycle after i_re; write lands at the edge.
// Backpressure: none; the owning FSM issues at most one access per cycle.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8,
    parameter int NB     = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [NB-1:0]     i_lane_mask,
    output logic [DATA_W-1:0] o_rdata
);

    // Contents are deliberately not reset so the array maps onto RAM.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write enabled byte lanes; capture the addressed word on a read.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_lane_mask[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory serving MEM-stage loads/stores (macro DMEM_BYTE_EN adds byte lanes).
// Latency: LATENCY+1 stall cycles per request, then a one-cycle RESP with load data.
// Backpressure: o_mem_stall freezes the pipeline; request inputs must stay stable while it is high.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = DMEM_DEF_LATENCY
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]        i_be,
`endif
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_stall,
    output logic              o_resp_valid,
    output logic              o_addr_err
);

    // DEPTH_WORDS must be a power of 2 and LATENCY within 1..15.
    localparam int IDX_W = clog2(DEPTH_WORDS);
    localparam int NB    = DATA_W / 8;
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(LATENCY - 1);

`ifdef DMEM_BYTE_EN
    localparam logic USE_BE = 1'b1;
`else
    localparam logic USE_BE = 1'b0;
`endif

    dmem_state_t           r_state;
    dmem_state_t           w_state_nxt;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_is_store;
    logic [3:0]            r_be;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_req;
    logic                  w_capture;
    logic                  w_access;
    logic                  w_err;
    logic [3:0]            w_be_in;
    logic [IDX_W-1:0]      w_idx;
    logic [NB-1:0]         w_lane_mask;
    logic                  w_we;
    logic                  w_re;
    logic [DATA_W-1:0]     w_arr_rdata;
    logic [DATA_W-1:0]     w_load_data;

    assign w_req = i_mem_read | i_mem_write;

`ifdef DMEM_BYTE_EN
    assign w_be_in = i_be;
`else
    assign w_be_in = 4'hF;
`endif

    // Checks run on the captured copy, which stays valid through RESP.
    assign w_err       = dmem_addr_err(64'(r_addr), DEPTH_WORDS, r_is_store, r_be, USE_BE);
    assign w_idx       = r_addr[IDX_W+1:2];
    assign w_lane_mask = NB'(r_be);
    assign w_we        = w_access & r_is_store & ~w_err;
    assign w_re        = w_access & ~r_is_store & ~w_err;
    assign w_load_data = w_err ? '0 : w_arr_rdata;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept in IDLE, count down in BUSY, one RESP cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the request, run the wait counter, hold the last load result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_store <= 1'b0;
            r_be       <= 4'h0;
            r_rdata    <= '0;
        end else begin
            if (w_capture) begin
                r_cnt      <= CNT_INIT;
                r_addr     <= i_addr;
                r_wdata    <= i_wdata;
                // A simultaneous read+write request is treated as a store.
                r_is_store <= i_mem_write;
                r_be       <= w_be_in;
            end else if (r_state == ST_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == ST_RESP && !r_is_store) begin
                r_rdata <= w_load_data;
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH_WORDS),
        .IDX_W  (IDX_W),
        .NB     (NB)
    ) u_array (
        .i_clk       (i_clk),
        .i_we        (w_we),
        .i_re        (w_re),
        .i_idx       (w_idx),
        .i_wdata     (r_wdata),
        .i_lane_mask (w_lane_mask),
        .o_rdata     (w_arr_rdata)
    );

    // Stall is combinational in IDLE so the pipeline freezes in the detection
    // cycle; reset forces it low even while the frozen request is still held.
    assign o_mem_stall  = ~i_rst & (((r_state == ST_IDLE) & w_req) | (r_state == ST_BUSY));
    assign o_resp_valid = (r_state == ST_RESP);
    assign o_addr_err   = (r_state == ST_RESP) & w_err;
    // The array's registered read is presented directly in RESP, then held.
    assign o_rdata      = (r_state == ST_RESP && !r_is_store) ? w_load_data : r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with hand-computed expectations.
// Each task drives one scenario and compares outputs at negedge+1.
// Byte-lane scenarios build only when DMEM_BYTE_EN is defined.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        mem_stall;
    logic        resp_valid;
    logic        addr_err;

    int checks;
    int failures;

    data_mem_responder #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH_WORDS (256),
        .LATENCY     (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_addr       (addr),
        .i_wdata      (wdata),
`ifdef DMEM_BYTE_EN
        .i_be         (be),
`endif
        .o_rdata      (rdata),
        .o_mem_stall  (mem_stall),
        .o_resp_valid (resp_valid),
        .o_addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Issues one request starting now (negedge+1 region) and waits for RESP.
    // If called during a RESP cycle the request is seen in the next IDLE cycle.
    task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, output int stalls,
                             output logic [31:0] rd, output logic err, output logic got);
        mem_write = wr;
        mem_read  = ~wr;
        addr      = a;
        wdata     = d;
        be        = b;
        stalls    = 0;
        got       = 1'b0;
        rd        = '0;
        err       = 1'b0;
        #1;
        if (resp_valid) begin
            @(negedge clk);
            #1;
        end
        for (int c = 0; c < 40 && !got; c++) begin
            if (resp_valid) begin
                rd  = rdata;
                err = addr_err;
                got = 1'b1;
            end else begin
                if (mem_stall) stalls++;
                @(negedge clk);
                #1;
            end
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0; be = 4'hF;
        idle(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({mem_stall, resp_valid, addr_err} !== 3'b000) begin
                failures++;
                $display("FAIL reset_idle_ctrl cycle %0d: got %b expected 000", i, {mem_stall, resp_valid, addr_err});
            end
            checks++;
            if (rdata !== 32'h0) begin
                failures++;
                $display("FAIL reset_idle_rdata cycle %0d: got %h expected 00000000", i, rdata);
            end
        end
    endtask

    task automatic test_store_load;
        int s; logic [31:0] rd; logic e; logic g;
        do_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, s, rd, e, g);
        checks++;
        if (!g || s != 3 || e !== 1'b0) begin
            failures++;
            $display("FAIL store_0x10: got resp=%0b stalls=%0d err=%b expected resp=1 stalls=3 err=0", g, s, e);
        end
        idle(1);
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL resp_pulse_width: got %b expected 0", resp_valid);
        end
        do_access(1'b0, 32'h10, 32'h0, 4'hF, s, rd, e, g);
        checks++;
        if (!g || s != 3 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
            failures++;
            $display("FAIL load_0x10: got resp=%0b stalls=%0d rdata=%h err=%b expected 1 3 deadbeef 0", g, s, rd, e);
        end
        idle(3);
        checks++;
        if (rdata !== 32'hDEADBEEF || mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL rdata_hold_idle: got rdata=%h stall=%b expected deadbeef 0", rdata, mem_stall);
        end
    endtask

    task automatic test_back_to_back;
        int s; logic [31:0] rd; logic e; logic g;
        idle(1);
        do_access(1'b1, 32'h04, 32'h1, 4'hF, s, rd, e, g);
        checks++;
        if (!g || s != 3) begin
            failures++;
            $display("FAIL b2b_store: got resp=%0b stalls=%0d expected 1 3", g, s);
        end
        do_access(1'b0, 32'h04, 32'h0, 4'hF, s, rd, e, g);
        checks++;
        if (!g || s != 3 || rd !== 32'h1) begin
            failures++;
            $display("FAIL b2b_load: got resp=%0b stalls=%0d rdata=%h expected 1 3 00000001", g, s, rd);
        end
        do_access(1'b1, 32'h08, 32'h600D, 4'hF, s, rd, e, g);
        checks++;
        if (!g || rdata !== 32'h1) begin
            failures++;
            $display("FAIL rdata_hold_store: got resp=%0b rdata=%h expected 1 00000001", g, rdata);
        end
        idle(2);
    endtask

    task automatic test_errors;
        int s; logic [31:0] rd; logic e; logic g;
        logic [3:0] mis_be;
`ifdef DMEM_BYTE_EN
        mis_be = 4'b0110;
`else
        mis_be = 4'hF;
`endif
        do_access(1'b1, 32'h13, 32'hCAFEF00D, mis_be, s, rd, e, g);
        checks++;
        if (!g || e !== 1'b1 || s != 3) begin
            failures++;
            $display("FAIL misaligned_store: got resp=%0b err=%b stalls=%0d expected 1 1 3", g, e, s);
        end
        idle(1);
        checks++;
        if (addr_err !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse_width: got %b expected 0", addr_err);
        end
        do_access(1'b0, 32'h10, 32'h0, 4'hF, s, rd, e, g);
        checks++;
        if (!g || rd !== 32'hDEADBEEF || e !== 1'b0) begin
            failures++;
            $display("FAIL after_misaligned_load: got rdata=%h err=%b expected deadbeef 0", rd, e);
        end
        do_access(1'b0, 32'h400, 32'h0, 4'hF, s, rd, e, g);
        checks++;
        if (!g || rd !== 32'h0 || e !== 1'b1) begin
            failures++;
            $display("FAIL range_load: got rdata=%h err=%b expected 00000000 1", rd, e);
        end
        idle(2);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL range_load_hold: got %h expected 00000000", rdata);
        end
        do_access(1'b1, 32'h0, 32'h12345678, 4'hF, s, rd, e, g);
        do_access(1'b1, 32'h400, 32'h00000BAD, 4'hF, s, rd, e, g);
        checks++;
        if (!g || e !== 1'b1) begin
            failures++;
            $display("FAIL range_store: got resp=%0b err=%b expected 1 1", g, e);
        end
        do_access(1'b0, 32'h0, 32'h0, 4'hF, s, rd, e, g);
        checks++;
        if (rd !== 32'h12345678 || e !== 1'b0) begin
            failures++;
            $display("FAIL range_store_no_alias: got rdata=%h err=%b expected 12345678 0", rd, e);
        end
        do_access(1'b1, 32'h3FC, 32'h55, 4'hF, s, rd, e, g);
        do_access(1'b0, 32'h3FC, 32'h0, 4'hF, s, rd, e, g);
        checks++;
        if (!g || rd !== 32'h55 || e !== 1'b0) begin
            failures++;
            $display("FAIL last_word: got rdata=%h err=%b expected 00000055 0", rd, e);
        end
        // Both strobes high acts as a store with no error.
        mem_read = 1'b1; mem_write = 1'b1; addr = 32'h0C; wdata = 32'h0BB0;
        #1;
        if (resp_valid) begin @(negedge clk); #1; end
        idle(3);
        checks++;
        if (resp_valid !== 1'b1 || addr_err !== 1'b0) begin
            failures++;
            $display("FAIL both_strobes: got resp=%b err=%b expected 1 0", resp_valid, addr_err);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        do_access(1'b0, 32'h0C, 32'h0, 4'hF, s, rd, e, g);
        checks++;
        if (rd !== 32'h0BB0) begin
            failures++;
            $display("FAIL both_strobes_data: got %h expected 00000bb0", rd);
        end
        idle(2);
    endtask

    task automatic test_reset_mid;
        int s; logic [31:0] rd; logic e; logic g;
        do_access(1'b0, 32'h08, 32'h0, 4'hF, s, rd, e, g);
        idle(2);
        mem_write = 1'b1; mem_read = 1'b0; addr = 32'h08; wdata = 32'h77;
        @(negedge clk);
        #1;
        checks++;
        if (mem_stall !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy_stall: got %b expected 1", mem_stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_stall, resp_valid, addr_err} !== 3'b000 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got ctrl=%b rdata=%h expected 000 00000000", {mem_stall, resp_valid, addr_err}, rdata);
        end
        @(negedge clk);
        mem_write = 1'b0;
        rst = 1'b0;
        #1;
        idle(2);
        checks++;
        if (mem_stall !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_idle: got stall=%b resp=%b expected 0 0", mem_stall, resp_valid);
        end
        do_access(1'b0, 32'h08, 32'h0, 4'hF, s, rd, e, g);
        checks++;
        if (!g || rd !== 32'h600D) begin
            failures++;
            $display("FAIL mid_reset_word: got rdata=%h expected 0000600d", rd);
        end
        idle(2);
    endtask

`ifdef DMEM_BYTE_EN
    task automatic test_byte_en;
        int s; logic [31:0] rd; logic e; logic g;
        do_access(1'b1, 32'h20, 32'h11223344, 4'b1111, s, rd, e, g);
        do_access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0010, s, rd, e, g);
        checks++;
        if (!g || e !== 1'b0) begin
            failures++;
            $display("FAIL be_lane1_store: got resp=%0b err=%b expected 1 0", g, e);
        end
        do_access(1'b0, 32'h20, 32'h0, 4'b0000, s, rd, e, g);
        checks++;
        if (rd !== 32'h1122CC44) begin
            failures++;
            $display("FAIL be_lane1_read: got %h expected 1122cc44", rd);
        end
        do_access(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, s, rd, e, g);
        checks++;
        if (!g || e !== 1'b1) begin
            failures++;
            $display("FAIL be_zero_err: got resp=%0b err=%b expected 1 1", g, e);
        end
        do_access(1'b0, 32'h20, 32'h0, 4'b0000, s, rd, e, g);
        checks++;
        if (rd !== 32'h1122CC44) begin
            failures++;
            $display("FAIL be_zero_nochange: got %h expected 1122cc44", rd);
        end
        idle(2);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_reset_mid();
`ifdef DMEM_BYTE_EN
        test_byte_en();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
